// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: parametrised inter-stage pipeline register for the five-stage core.
// It carries an opaque payload plus a valid bit between two adjacent stages and
// supports flush, bubble insertion and hold. It also returns a multi-cycle side
// channel (temp value and cycle count) to the upstream stage while that stage is stalled.
// Optional feature macro: PIPE_STAT_EN builds saturating bubble/hold statistics
// counters. When the macro is undefined, both counters are tied to zero.
module pipe_stage_reg #(
    parameter int                DATA_W    = 32,
    parameter logic [DATA_W-1:0] NOP_VALUE = '0,
    parameter int                STALL_W   = 6,
    parameter int                STAGE_IDX = 3,
    parameter int                TMP_W     = 64,
    parameter int                CNT_W     = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall,
    input  logic               flush,
    input  logic               in_valid,
    input  logic [DATA_W-1:0]  in_data,
    output logic               out_valid,
    output logic [DATA_W-1:0]  out_data,
    input  logic [TMP_W-1:0]   mc_tmp_i,
    input  logic [CNT_W-1:0]   mc_cnt_i,
    output logic [TMP_W-1:0]   mc_tmp_o,
    output logic [CNT_W-1:0]   mc_cnt_o,
    output logic [1:0]         mode,
    output logic [15:0]        bubble_cnt,
    output logic [15:0]        hold_cnt
);

    typedef enum logic [1:0] {
        MODE_IDLE   = 2'd0,
        MODE_PASS   = 2'd1,
        MODE_BUBBLE = 2'd2,
        MODE_HOLD   = 2'd3
    } mode_t;

    if (STAGE_IDX > STALL_W - 2 || STAGE_IDX < 0 || DATA_W < 1 || TMP_W < 1 || CNT_W < 1) begin : g_param_check
        $error("pipe_stage_reg: illegal parameters (STAGE_IDX=%0d STALL_W=%0d DATA_W=%0d TMP_W=%0d CNT_W=%0d)",
               STAGE_IDX, STALL_W, DATA_W, TMP_W, CNT_W);
    end

    logic  su;
    logic  sd;
    mode_t next_mode;
    logic  stall_unused;

    assign su = stall[STAGE_IDX];
    assign sd = stall[STAGE_IDX+1];
    // Only two stall bits matter here; the rest of the vector belongs to other stages.
    assign stall_unused = ^stall;

    // Pick this edge's action: flush > bubble > pass > hold. su=0,sd=1 falls into pass.
    always_comb begin
        next_mode = MODE_PASS;
        if (flush) begin
            next_mode = MODE_IDLE;
        end else if (su && !sd) begin
            next_mode = MODE_BUBBLE;
        end else if (!su) begin
            next_mode = MODE_PASS;
        end else begin
            next_mode = MODE_HOLD;
        end
    end

    // Payload, valid, side channel and mode registers; hold simply keeps everything but mode.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_data  <= NOP_VALUE;
            mc_tmp_o  <= '0;
            mc_cnt_o  <= '0;
            mode      <= MODE_IDLE;
        end else begin
            mode <= next_mode;
            case (next_mode)
                MODE_IDLE: begin
                    out_valid <= 1'b0;
                    out_data  <= NOP_VALUE;
                    mc_tmp_o  <= '0;
                    mc_cnt_o  <= '0;
                end
                MODE_BUBBLE: begin
                    // The upstream multi-cycle op keeps its partial result while it is stalled.
                    out_valid <= 1'b0;
                    out_data  <= NOP_VALUE;
                    mc_tmp_o  <= mc_tmp_i;
                    mc_cnt_o  <= mc_cnt_i;
                end
                MODE_PASS: begin
                    out_valid <= in_valid;
                    out_data  <= in_valid ? in_data : NOP_VALUE;
                    mc_tmp_o  <= '0;
                    mc_cnt_o  <= '0;
                end
                default: begin
                end
            endcase
        end
    end

`ifdef PIPE_STAT_EN
    // Saturating statistics; flush leaves them alone and only reset clears them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bubble_cnt <= 16'h0000;
            hold_cnt   <= 16'h0000;
        end else begin
            if (next_mode == MODE_BUBBLE && bubble_cnt != 16'hFFFF) begin
                bubble_cnt <= bubble_cnt + 16'd1;
            end
            if (next_mode == MODE_HOLD && hold_cnt != 16'hFFFF) begin
                hold_cnt <= hold_cnt + 16'd1;
            end
        end
    end
`else
    assign bubble_cnt = 16'h0000;
    assign hold_cnt   = 16'h0000;
`endif

`ifndef SYNTHESIS
    // The stall controller never stops downstream while upstream keeps running.
    illegal_stall_a : assert property (@(posedge clk) disable iff (!rst) !(!su && sd))
        else $error("pipe_stage_reg: illegal stall combination su=0 sd=1");
`endif

endmodule
